// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clk_in divider with run/stop, single-step and glitch-free divisor updates
module clk_div_prog #(
   parameter int          CNT_W    = 18,
   parameter int unsigned DEF_HALF = 199_999
)(
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic             step_req,
   input  logic             div_wr,
   input  logic [CNT_W-1:0] div_data,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic             div_pend,
   output logic [CNT_W-1:0] cur_half
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, STEP} state_t;
   state_t state, nxt;
   logic [CNT_W-1:0] cnt, pend;
   logic bnd, stop_now, tog, apply;
   // half-period boundary, stop-from-low handling and next-state selection
   always_comb begin
      bnd = state != IDLE && cnt == cur_half;
      stop_now = state == RUN && !en && !clk_out;
      tog = bnd && !stop_now;
      apply = div_pend && (state == IDLE || tog);
      nxt = state;
      case (state)
         IDLE:    nxt = en ? RUN : step_req ? STEP : IDLE;
         RUN:     nxt = en ? RUN : (!clk_out || bnd) ? IDLE : DRAIN;
         DRAIN:   nxt = en ? RUN : bnd ? IDLE : DRAIN;
         default: nxt = (bnd && clk_out) ? IDLE : STEP;
      endcase
   end
   // state, counter, output clock and divisor registers
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
         busy     <= 1'b0;
         div_pend <= 1'b0;
         cur_half <= CNT_W'(DEF_HALF);
         pend     <= '0;
      end else begin
         state    <= nxt;
         busy     <= nxt != IDLE;
         cnt      <= (state == IDLE || stop_now || bnd) ? '0 : cnt + 1'b1;
         clk_out  <= clk_out ^ tog;
         tick     <= tog && !clk_out;
         cur_half <= apply ? pend : cur_half;
         div_pend <= div_wr || (div_pend && !apply);
         pend     <= div_wr ? div_data : pend;
      end
   end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: randomized self-checking bench for clk_div_prog against arithmetic timing predictions
module tb_clk_div_prog;
   localparam int W = 18;
   logic clk_in = 1'b0, rst_n = 1'b0, en = 1'b0, step_req = 1'b0, div_wr = 1'b0;
   logic [W-1:0] div_data = '0;
   logic clk_out, tick, busy, div_pend;
   logic [W-1:0] cur_half;
   int checks = 0, failures = 0;

   clk_div_prog #(.CNT_W(W), .DEF_HALF(3)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .en(en), .step_req(step_req),
      .div_wr(div_wr), .div_data(div_data), .clk_out(clk_out), .tick(tick),
      .busy(busy), .div_pend(div_pend), .cur_half(cur_half)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic adv;
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_h(input int h);
      div_wr = 1'b1;
      div_data = W'(h);
      adv();
      div_wr = 1'b0;
      adv();
      checks++;
      if (cur_half !== W'(h) || div_pend !== 1'b0) begin
         failures++;
         $display("FAIL set_h got cur_half=%0d pend=%b want %0d/0", cur_half, div_pend, h);
      end
   endtask

   task automatic go_idle;
      int n = 0;
      en = 1'b0;
      step_req = 1'b0;
      div_wr = 1'b0;
      while (busy !== 1'b0 && n < 100) begin
         adv();
         n++;
      end
      checks++;
      if (busy !== 1'b0 || clk_out !== 1'b0) begin
         failures++;
         $display("FAIL go_idle busy=%b clk_out=%b after %0d cycles", busy, clk_out, n);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      checks++;
      if ({clk_out, tick, busy, div_pend, cur_half} !== {4'b0000, W'(3)}) begin
         failures++;
         $display("FAIL reset_hold got %b%b%b%b half=%0d want 0000 half=3", clk_out, tick, busy, div_pend, cur_half);
      end
      #3 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         adv();
         checks++;
         if ({clk_out, tick, busy, div_pend, cur_half} !== {4'b0000, W'(3)}) begin
            failures++;
            $display("FAIL idle_hold cycle %0d got %b%b%b%b half=%0d", i, clk_out, tick, busy, div_pend, cur_half);
         end
      end
   endtask

   task automatic test_run(input int h, input bit with_step);
      int hp, d, lvl, b;
      logic [2:0] e;
      set_h(h);
      hp = h + 1;
      d = $urandom_range(1, 8 * hp);
      en = 1'b1;
      step_req = with_step;
      for (int r = 0; r < d; r++) begin
         adv();
         step_req = 1'b0;
         if (r == d - 1) en = 1'b0;
         e = {1'(((r / hp) % 2)), r > 0 && r % (2 * hp) == hp, 1'b1};
         checks++;
         if ({clk_out, tick, busy} !== e) begin
            failures++;
            $display("FAIL run h=%0d rel=%0d got clk/tick/busy=%b%b%b want %b", h, r, clk_out, tick, busy, e);
         end
      end
      lvl = ((d - 1) / hp) % 2;
      b = lvl == 1 ? ((d + hp - 1) / hp) * hp : d;
      for (int r = d; r <= b + 1; r++) begin
         adv();
         e = {r < b, 1'b0, r < b};
         checks++;
         if ({clk_out, tick, busy} !== e) begin
            failures++;
            $display("FAIL stop h=%0d drop=%0d rel=%0d got %b%b%b want %b", h, d, r, clk_out, tick, busy, e);
         end
      end
   endtask

   task automatic test_div_update;
      logic [2:0] e;
      logic [W-1:0] eh;
      set_h(3);
      en = 1'b1;
      for (int r = 0; r < 20; r++) begin
         adv();
         if (r == 5) begin div_wr = 1'b1; div_data = W'(5); end
         else if (r == 6) div_data = W'(1);
         else div_wr = 1'b0;
         e = r < 8 ? {1'((r / 4) % 2), r == 4, r >= 6} : {1'(((r - 8) / 2) % 2), (r - 8) % 4 == 2, 1'b0};
         eh = r < 8 ? W'(3) : W'(1);
         checks++;
         if ({clk_out, tick, div_pend, cur_half} !== {e, eh}) begin
            failures++;
            $display("FAIL div_update rel=%0d got clk/tick/pend=%b%b%b half=%0d want %b half=%0d", r, clk_out, tick, div_pend, cur_half, e, eh);
         end
      end
      go_idle();
   endtask

   task automatic test_step(input int h);
      int last, ticks = 0;
      logic [2:0] e;
      set_h(h);
      last = 2 * h + 2;
      en = 1'b0;
      step_req = 1'b1;
      for (int n = 0; n <= last + 2; n++) begin
         adv();
         step_req = n == h;
         if (tick === 1'b1) ticks++;
         e = {n >= h + 1 && n < last, n == h + 1, n < last};
         checks++;
         if ({clk_out, tick, busy} !== e) begin
            failures++;
            $display("FAIL step h=%0d rel=%0d got clk/tick/busy=%b%b%b want %b", h, n, clk_out, tick, busy, e);
         end
      end
      step_req = 1'b0;
      checks++;
      if (ticks != 1) begin
         failures++;
         $display("FAIL step_ticks h=%0d got %0d want 1", h, ticks);
      end
   endtask

   task automatic test_h0;
      logic [2:0] e;
      logic [W-1:0] eh;
      set_h(0);
      en = 1'b1;
      div_data = W'(2);
      for (int r = 0; r < 15; r++) begin
         adv();
         div_wr = r == 4;
         e = r <= 5 ? {1'(r % 2), r % 2 == 1, r == 5} : {1'(((r - 6) / 3) % 2), (r - 6) % 6 == 3, 1'b0};
         eh = r <= 5 ? W'(0) : W'(2);
         checks++;
         if ({clk_out, tick, div_pend, cur_half} !== {e, eh}) begin
            failures++;
            $display("FAIL h0 rel=%0d got clk/tick/pend=%b%b%b half=%0d want %b half=%0d", r, clk_out, tick, div_pend, cur_half, e, eh);
         end
      end
      go_idle();
   endtask

   task automatic test_async_reset;
      set_h(2);
      en = 1'b1;
      div_data = W'(7);
      for (int r = 0; r < 5; r++) begin
         adv();
         div_wr = r == 3;
      end
      checks++;
      if ({clk_out, div_pend, busy} !== 3'b111) begin
         failures++;
         $display("FAIL pre_reset got clk/pend/busy=%b%b%b want 111", clk_out, div_pend, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({clk_out, tick, busy, div_pend, cur_half} !== {4'b0000, W'(3)}) begin
         failures++;
         $display("FAIL async_reset got %b%b%b%b half=%0d want 0000 half=3", clk_out, tick, busy, div_pend, cur_half);
      end
      en = 1'b0;
      adv();
      #2 rst_n = 1'b1;
      adv();
      adv();
      checks++;
      if ({clk_out, tick, busy, div_pend, cur_half} !== {4'b0000, W'(3)}) begin
         failures++;
         $display("FAIL post_reset got %b%b%b%b half=%0d want 0000 half=3", clk_out, tick, busy, div_pend, cur_half);
      end
   endtask

   initial begin
      test_reset();
      for (int i = 0; i < 8; i++) test_run($urandom_range(0, 5), i == 0);
      test_div_update();
      for (int i = 0; i < 3; i++) test_step($urandom_range(0, 5));
      test_h0();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
